// File: rtl/rr_reg_bank_arbiter.sv
// rr_reg_bank_arbiter
//   Round-robin arbiter that gives NREQ control masters exclusive, one-access
//   turns at a shared bank of 2**ADDR_W flip-flop registers (DATA_W bits each).
//   A turn is IDLE (pick winner, latch its command) -> ACCESS (read or write
//   the bank) -> DONE (one-cycle ack), i.e. at most one access per 3 cycles.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [NREQ]          level request per requester, held until ack
//   we       in   [NREQ]          1 = write, 0 = read
//   addr     in   [NREQ*ADDR_W]   requester i address at [i*ADDR_W +: ADDR_W]
//   wdata    in   [NREQ*DATA_W]   requester i data at [i*DATA_W +: DATA_W]
//   grant    out  [NREQ]          one-hot, requester being serviced (ACCESS)
//   ack      out  [NREQ]          one-hot, one-cycle completion pulse (DONE)
//   rdata    out  [DATA_W]        read data, valid while ack is high
//   busy     out                  high whenever not IDLE
//   bank_q   out  [DEPTH*DATA_W]  whole bank, register k at [k*DATA_W +: DATA_W]
module rr_reg_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0]                we,
  input  logic [NREQ*ADDR_W-1:0]         addr,
  input  logic [NREQ*DATA_W-1:0]         wdata,
  output logic [NREQ-1:0]                grant,
  output logic [NREQ-1:0]                ack,
  output logic [DATA_W-1:0]              rdata,
  output logic                           busy,
  output logic [(2**ADDR_W)*DATA_W-1:0]  bank_q
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic [NREQ-1:0]     grant_q;
  logic [NREQ-1:0]     ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic [IDX_W-1:0]    last_q;
  logic [DATA_W-1:0]   bank_r [DEPTH];

  // Command of the current winner, captured in IDLE.
  logic [IDX_W-1:0]    win_q;
  logic                we_l_q;
  logic [ADDR_W-1:0]   addr_l_q;
  logic [DATA_W-1:0]   wdata_l_q;

  logic [IDX_W-1:0]    win_d;

  // Round-robin search: start one past the last winner and wrap, so the
  // requester just serviced has the lowest priority on the next turn.
  always_comb begin
    int               idx;
    logic             found;
    logic [IDX_W-1:0] cand;
    win_d = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last_q) + k) % NREQ;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win_d = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDX_W'(NREQ - 1);
      for (int k = 0; k < DEPTH; k++) bank_r[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= NREQ'(1) << win_d;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_l_q) bank_r[addr_l_q] <= wdata_l_q;
          else        rdata_q          <= bank_r[addr_l_q];
          ack_q   <= grant_q;
          grant_q <= '0;
          last_q  <= win_q;
          state_q <= DONE;
        end
        DONE: begin
          // req is deliberately ignored here; the requester drops it now.
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Command capture needs no reset: it is always rewritten before ACCESS uses it.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && |req) begin
      win_q     <= win_d;
      we_l_q    <= we[win_d];
      addr_l_q  <= addr[win_d*ADDR_W +: ADDR_W];
      wdata_l_q <= wdata[win_d*DATA_W +: DATA_W];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign bank_q[k*DATA_W +: DATA_W] = bank_r[k];
  end

  assign grant = grant_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rr_reg_bank_arbiter.sv
module tb_rr_reg_bank_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 2**ADDR_W;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           we;
  logic [NREQ*ADDR_W-1:0]    addr;
  logic [NREQ*DATA_W-1:0]    wdata;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [DEPTH*DATA_W-1:0]   bank_q;

  rr_reg_bank_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant), .ack(ack), .rdata(rdata), .busy(busy), .bank_q(bank_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]         ack;
    bit                      rd;
    logic [DATA_W-1:0]       rdata;
    logic [DEPTH*DATA_W-1:0] bank;
  } item_t;

  item_t             sb[$];
  logic [DATA_W-1:0] mdl [DEPTH];
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DEPTH*DATA_W-1:0] flat();
    logic [DEPTH*DATA_W-1:0] r;
    for (int k = 0; k < DEPTH; k++) r[k*DATA_W +: DATA_W] = mdl[k];
    return r;
  endfunction

  // Expected completion of requester i; the bank model advances in grant order.
  task automatic push(input int i, input bit w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    item_t it;
    it.ack    = '0;
    it.ack[i] = 1'b1;
    it.rd     = !w;
    it.rdata  = mdl[a];
    if (w) mdl[a] = d;
    it.bank   = flat();
    sb.push_back(it);
  endtask

  task automatic drive(input int i, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*ADDR_W +: ADDR_W]  = a;
    wdata[i*DATA_W +: DATA_W] = d;
    push(i, w, a, d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full turn: grant cycle, ack cycle (drop requests here), back to IDLE.
  task automatic do_grant(input logic [NREQ-1:0] g, input logic [NREQ-1:0] drop);
    step();
    check("grant", grant, g);
    check("busy_access", busy, 1'b1);
    check("ack_in_access", ack, '0);
    step();
    req = req & ~drop;
    step();
  endtask

  // Scoreboard side: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (reset_n && ack !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", ack, '0);
      end else begin
        item_t it;
        it = sb.pop_front();
        check("ack", ack, it.ack);
        check("grant_with_ack", grant, '0);
        if (it.rd) check("rdata", rdata, it.rdata);
        check("bank_at_ack", bank_q, it.bank);
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
    #1 reset_n = 1'b0;

    // Reset held with every requester asking.
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, ADDR_W'(i), DATA_W'(8'h10 + i));
    repeat (3) step();
    check("rst_grant", grant, '0);
    check("rst_ack", ack, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_bank", bank_q, '0);
    check("rst_rdata", rdata, '0);

    // Rotation 0,1,2,3,0 with all requests held.
    reset_n = 1'b1;
    for (int k = 0; k < NREQ; k++) do_grant(NREQ'(1) << k, '0);
    push(0, 1'b1, 2'd0, 8'h10);
    do_grant(4'b0001, 4'b1111);
    check("idle_busy", busy, 1'b0);

    // Single write then read-back.
    drive(2, 1'b1, 2'd1, 8'hA5);
    do_grant(4'b0100, 4'b0100);
    check("bank_byte1", bank_q[15:8], 8'hA5);
    drive(0, 1'b0, 2'd1, 8'h00);
    do_grant(4'b0001, 4'b0001);
    check("rdata_hold", rdata, 8'hA5);

    // Pointer wrap and skip.
    drive(1, 1'b0, 2'd2, 8'h00);
    do_grant(4'b0010, 4'b0010);
    drive(3, 1'b0, 2'd3, 8'h00);
    drive(0, 1'b1, 2'd2, 8'h5A);
    do_grant(4'b1000, 4'b1000);
    do_grant(4'b0001, 4'b0001);
    drive(3, 1'b1, 2'd3, 8'hC3);
    do_grant(4'b1000, 4'b1000);
    drive(0, 1'b0, 2'd2, 8'h00);
    drive(1, 1'b0, 2'd3, 8'h00);
    do_grant(4'b0001, 4'b0001);
    do_grant(4'b0010, 4'b0010);

    // Requester 1 holds req while 3 joins, then 1 runs back-to-back.
    drive(1, 1'b0, 2'd0, 8'h00);
    do_grant(4'b0010, '0);
    drive(3, 1'b1, 2'd0, 8'h77);
    push(1, 1'b0, 2'd0, 8'h00);
    do_grant(4'b1000, 4'b1000);
    do_grant(4'b0010, '0);
    push(1, 1'b0, 2'd0, 8'h00);
    do_grant(4'b0010, '0);
    push(1, 1'b0, 2'd0, 8'h00);
    do_grant(4'b0010, 4'b0010);

    // Command changes after grant are ignored.
    drive(2, 1'b1, 2'd3, 8'h3C);
    step();
    check("latch_grant", grant, 4'b0100);
    addr[2*ADDR_W +: ADDR_W]  = 2'd0;
    wdata[2*DATA_W +: DATA_W] = 8'hFF;
    step();
    req[2] = 1'b0;
    step();
    check("latch_bank3", bank_q[31:24], 8'h3C);
    check("latch_bank0", bank_q[7:0], 8'h77);
    check("rdata_hold_wr", rdata, 8'h77);

    // Asynchronous reset in the middle of ACCESS aborts the write.
    req[0] = 1'b1; we[0] = 1'b1;
    addr[0 +: ADDR_W] = 2'd1; wdata[0 +: DATA_W] = 8'hEE;
    step();
    check("abort_grant", grant, 4'b0001);
    #2 reset_n = 1'b0;
    #1;
    check("async_grant", grant, '0);
    check("async_busy", busy, 1'b0);
    check("async_bank", bank_q, '0);
    check("async_rdata", rdata, '0);
    for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
    req = '0;
    step();
    check("abort_ack", ack, '0);
    check("abort_bank", bank_q, '0);
    reset_n = 1'b1;

    // Requester 0 has top priority again after reset.
    drive(0, 1'b0, 2'd1, 8'h00);
    drive(3, 1'b0, 2'd2, 8'h00);
    do_grant(4'b0001, 4'b0001);
    do_grant(4'b1000, 4'b1000);

    for (int c = 0; c < 20 && sb.size() != 0; c++) step();
    check("sb_drain", 64'(sb.size()), 64'd0);
    check("end_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_reg_bank_arbiter.md
Name: rr_reg_bank_arbiter

Overview:
- Shares one bank of flip-flop configuration registers between NREQ requesters using round-robin arbitration.
- Each granted requester performs exactly one read or write access.
- Completion is signalled with a one-cycle ack.
- Sits between control masters (e.g. sequencers, host interface) and the system configuration registers.
- Drives the full bank contents onto a flat output so downstream logic can consume them.

Parameters:
- NREQ, 4, number of requesters (≥2).
- DATA_W, 8, register width in bits.
- ADDR_W, 2, register address width; bank depth = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester access request; level, held until ack.
- we  input  NREQ  per-requester write enable; 1 = write, 0 = read.
- addr  input  NREQ*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  input  NREQ*DATA_W  per-requester write data; slice [i*DATA_W +: DATA_W].
- grant  output  NREQ  one-hot: currently serviced requester.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  read data, valid while ack is high.
- busy  output  1  high whenever the FSM is not in IDLE.
- bank_q  output  (2**ADDR_W)*DATA_W  all registers flattened; register k at [k*DATA_W +: DATA_W].

Behaviour:
- Reset is asynchronous: reset_n low immediately forces all of the following, regardless of clk:
  - state = IDLE
  - grant = 0, ack = 0, rdata = 0, busy = 0
  - all bank registers = 0
  - round-robin pointer last = NREQ-1, so requester 0 has top priority after reset
- Reset mid-access aborts the access: no write, no ack.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If req != 0, select the winner by searching from last+1 upward with wrap modulo NREQ; the first set req bit wins.
  - Latch the winner's we, addr and wdata.
  - Set grant to the one-hot winner and go to ACCESS.
  - If req == 0, stay in IDLE.
- ACCESS (one cycle, grant held):
  - Write: bank[addr_latched] <= wdata_latched at the closing edge.
  - Read: rdata <= bank[addr_latched].
  - At the same edge: ack <= grant, last <= winner index, grant <= 0; go to DONE.
- DONE (one cycle): ack high and rdata valid. req is not sampled. At the next edge clear ack and go to IDLE.
- Latency: req seen high at edge E → grant high after E → ack high after E+1 → back in IDLE after E+2. Maximum throughput is one access per 3 cycles.
- Write visibility: a write is visible on bank_q from the start of the DONE cycle.
- Read data: rdata holds its last value after ack and changes only on a read.
- Requester obligations:
  - Deassert req during the DONE cycle; req still high in IDLE is treated as a new request.
  - Changing we, addr or wdata after grant has no effect; values are latched in IDLE.
- Fairness: while several requesters hold req, grants rotate strictly. No requester waits more than NREQ-1 other grants.
- Simultaneous requests: resolved only by the round-robin order; there is no fixed priority except immediately after reset.
- A req bit dropping in IDLE before being sampled produces no access.
- grant and ack are never both non-zero in the same cycle; each is always zero or one-hot.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 → grant=0, ack=0, busy=0, bank_q=0. Assert reset_n=0 during ACCESS → no ack, bank unchanged (zero).
- Single write then read: req[2] writes 8'hA5 to addr 1 → grant=4'b0100 for 1 cycle, then ack=4'b0100 for 1 cycle, bank_q[15:8]=8'hA5. Read of addr 1 by req[0] → rdata=8'hA5 during ack.
- Round-robin rotation: all four req held high from reset → grant sequence 0,1,2,3,0, each followed by its ack, 3 cycles per grant.
- Pointer wrap and skip: last=1, req=4'b1001 → grant 3 before 0. Then with last=3, req=4'b0011 → grant 0.
- Held req: requester 1 keeps req high through IDLE while req[3] is also high → next grant goes to 3, then 1. Requester 1 alone holding req → back-to-back accesses every 3 cycles.
- Latching: change addr and wdata of the granted requester during ACCESS → the originally sampled address and data are written.
